// File: rtl/id_ex_stage_pkg.sv
// Shared widths and ALU opcode encodings for the ID/EX slot and its neighbours.
package id_ex_stage_pkg;

    localparam int REG_WIDTH      = 32;
    localparam int ALU_OP_WIDTH   = 4;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'h0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'h1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'h2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'h3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'h4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'h5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'h6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'h7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'h8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'h9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LUI  = 4'hA;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-ID/EX bus: valid/ready handshake plus the decoded instruction fields.
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = REG_WIDTH,
    parameter int OPW  = ALU_OP_WIDTH,
    parameter int RAW  = REG_ADDR_WIDTH
);
    logic            id_valid;
    logic            id_ready;
    logic [OPW-1:0]  id_alu_op;
    logic [RAW-1:0]  id_rs1_addr;
    logic [RAW-1:0]  id_rs2_addr;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic            id_src1_pc;
    logic            id_src2_imm;
    logic [RAW-1:0]  id_rd_addr;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_branch;

    // Decode side offers instructions.
    modport master (
        output id_valid, id_alu_op, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_pc, id_src1_pc, id_src2_imm, id_rd_addr,
               id_reg_write, id_mem_read, id_mem_write, id_branch,
        input  id_ready
    );

    // Pipeline slot side accepts them.
    modport slave (
        input  id_valid, id_alu_op, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_pc, id_src1_pc, id_src2_imm, id_rd_addr,
               id_reg_write, id_mem_read, id_mem_write, id_branch,
        output id_ready
    );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Resolves one source operand against the MEM and WB result buses; MEM is newer so it wins.
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = REG_WIDTH,
    parameter int RAW  = REG_ADDR_WIDTH
) (
    input  logic [RAW-1:0]  src_addr,
    input  logic [XLEN-1:0] src_data,
    input  logic            mem_en,
    input  logic [RAW-1:0]  mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_en,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data,
    output logic            mem_hit,
    output logic            wb_hit
);
    // x0 is hardwired to zero, so it never matches a forwarding bus.
    assign mem_hit  = mem_en && (mem_rd == src_addr) && (src_addr != '0);
    assign wb_hit   = wb_en  && (wb_rd  == src_addr) && (src_addr != '0);
    assign fwd_data = mem_hit ? mem_data : (wb_hit ? wb_data : src_data);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline slot: one-entry buffer with operand forwarding, load-use stall and flush.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = REG_WIDTH,
    parameter int OPW  = ALU_OP_WIDTH,
    parameter int RAW  = REG_ADDR_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    id_ex_stage_if.slave    id_bus,
    input  logic            mem_fwd_en,
    input  logic [RAW-1:0]  mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            mem_fwd_is_load,
    input  logic            wb_fwd_en,
    input  logic [RAW-1:0]  wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [OPW-1:0]  alu_op,
    output logic [XLEN-1:0] alu_src1,
    output logic [XLEN-1:0] alu_src2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RAW-1:0]  ex_rd_addr,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic [XLEN-1:0] ex_pc
);
    logic            slot_valid;
    logic            slot_next;
    logic            fire_in;
    logic            fire_out;
    logic            load_use;

    logic [OPW-1:0]  op_reg;
    logic [RAW-1:0]  rs_addr_reg [2];
    logic [XLEN-1:0] rs_data_reg [2];
    logic [XLEN-1:0] imm_reg;
    logic [XLEN-1:0] pc_reg;
    logic            src1_pc_reg;
    logic            src2_imm_reg;
    logic [RAW-1:0]  rd_reg;
    logic            reg_write_reg;
    logic            mem_read_reg;
    logic            mem_write_reg;
    logic            branch_reg;

    logic [RAW-1:0]  id_rs_addr [2];
    logic [XLEN-1:0] id_rs_data [2];
    logic [XLEN-1:0] fwd_data   [2];
    logic [1:0]      mem_hit;
    logic [1:0]      wb_hit;
    logic [1:0]      src_used;

    assign id_rs_addr[0] = id_bus.id_rs1_addr;
    assign id_rs_addr[1] = id_bus.id_rs2_addr;
    assign id_rs_data[0] = id_bus.id_rs1_data;
    assign id_rs_data[1] = id_bus.id_rs2_data;

    // One resolver per source register: index 0 is rs1, index 1 is rs2.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        id_ex_stage_fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_mux (
            .src_addr (rs_addr_reg[gi]),
            .src_data (rs_data_reg[gi]),
            .mem_en   (mem_fwd_en),
            .mem_rd   (mem_fwd_rd),
            .mem_data (mem_fwd_data),
            .wb_en    (wb_fwd_en),
            .wb_rd    (wb_fwd_rd),
            .wb_data  (wb_fwd_data),
            .fwd_data (fwd_data[gi]),
            .mem_hit  (mem_hit[gi]),
            .wb_hit   (wb_hit[gi])
        );
    end

    // rs1 is irrelevant when src1 is the PC; rs2 still matters for a store even with an immediate src2.
    assign src_used[0] = ~src1_pc_reg;
    assign src_used[1] = ~src2_imm_reg | mem_write_reg;
    assign load_use    = slot_valid & mem_fwd_is_load & |(mem_hit & src_used);

    assign ex_valid       = slot_valid & ~load_use;
    assign fire_out       = ex_valid & ex_ready;
    assign id_bus.id_ready = ~slot_valid | fire_out;
    assign fire_in        = id_bus.id_valid & id_bus.id_ready;

    // Slot occupancy register; reset drops the slot without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= 1'b0;
        end else begin
            slot_valid <= slot_next;
        end
    end

    // Occupancy update: flush beats capture, capture beats drain.
    always_comb begin
        slot_next = slot_valid;
        if (flush) begin
            slot_next = 1'b0;
        end else if (fire_in) begin
            slot_next = 1'b1;
        end else if (fire_out) begin
            slot_next = 1'b0;
        end
    end

    // Instruction payload; a flushed capture is discarded rather than stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg        <= '0;
            imm_reg       <= '0;
            pc_reg        <= '0;
            src1_pc_reg   <= 1'b0;
            src2_imm_reg  <= 1'b0;
            rd_reg        <= '0;
            reg_write_reg <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            branch_reg    <= 1'b0;
        end else if (fire_in && !flush) begin
            op_reg        <= id_bus.id_alu_op;
            imm_reg       <= id_bus.id_imm;
            pc_reg        <= id_bus.id_pc;
            src1_pc_reg   <= id_bus.id_src1_pc;
            src2_imm_reg  <= id_bus.id_src2_imm;
            rd_reg        <= id_bus.id_rd_addr;
            reg_write_reg <= id_bus.id_reg_write;
            mem_read_reg  <= id_bus.id_mem_read;
            mem_write_reg <= id_bus.id_mem_write;
            branch_reg    <= id_bus.id_branch;
        end
    end

    // Source operands; while stalled, WB results are folded in so they survive retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rs_addr_reg[i] <= '0;
                rs_data_reg[i] <= '0;
            end
        end else if (fire_in && !flush) begin
            for (int i = 0; i < 2; i++) begin
                rs_addr_reg[i] <= id_rs_addr[i];
                rs_data_reg[i] <= id_rs_data[i];
            end
        end else if (slot_valid && !fire_out) begin
            for (int i = 0; i < 2; i++) begin
                if (wb_hit[i]) begin
                    rs_data_reg[i] <= wb_fwd_data;
                end
            end
        end
    end

    // Execute-side view: operand muxing and bubble masking of side-effecting flags.
    always_comb begin
        alu_op        = op_reg;
        alu_src1      = src1_pc_reg  ? pc_reg  : fwd_data[0];
        alu_src2      = src2_imm_reg ? imm_reg : fwd_data[1];
        ex_store_data = fwd_data[1];
        ex_rd_addr    = rd_reg;
        ex_pc         = pc_reg;
        ex_reg_write  = reg_write_reg & slot_valid;
        ex_mem_read   = mem_read_reg  & slot_valid;
        ex_mem_write  = mem_write_reg & slot_valid;
        ex_branch     = branch_reg    & slot_valid;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline slot sitting directly upstream of the ALU.
- Captures decoded operands and control from decode, resolves RAW hazards by forwarding from MEM and WB, and presents final alu_op/alu_src1/alu_src2 plus passthrough control to the execute stage.
- Valid/ready handshake on both sides; stalls on load-use hazards; supports flush on branch redirect.

Parameters:
- XLEN, 32, datapath width; equals REG_WIDTH.
- OPW, 4, ALU opcode width; equals ALU_OP_WIDTH.
- RAW, 5, register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- flush  in  1  kill slot contents and any same-cycle capture
- id_valid  in  1  decode offers an instruction
- id_ready  out  1  slot accepts the offered instruction this cycle
- id_alu_op  in  OPW  ALU operation
- id_rs1_addr, id_rs2_addr  in  RAW  source register indices
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  immediate
- id_pc  in  XLEN  instruction PC
- id_src1_pc  in  1  src1 selects PC (AUIPC/JAL)
- id_src2_imm  in  1  src2 selects immediate
- id_rd_addr  in  RAW  destination index
- id_reg_write, id_mem_read, id_mem_write, id_branch  in  1  control flags
- mem_fwd_en  in  1  MEM stage will write a register
- mem_fwd_rd  in  RAW  MEM destination index
- mem_fwd_data  in  XLEN  MEM result
- mem_fwd_is_load  in  1  MEM instruction is a load, so its data is not yet available
- wb_fwd_en  in  1  WB stage writes a register
- wb_fwd_rd  in  RAW  WB destination index
- wb_fwd_data  in  XLEN  WB result
- ex_valid  out  1  slot holds an issuable instruction
- ex_ready  in  1  execute consumes the slot
- alu_op  out  OPW  to ALU
- alu_src1, alu_src2  out  XLEN  to ALU, after forwarding and muxing
- ex_store_data  out  XLEN  forwarded rs2 value for stores
- ex_rd_addr  out  RAW
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1
- ex_pc  out  XLEN

Behaviour:
- Reset is asynchronous and active-low, on rst_n.
  - slot_valid=0 and all registered fields are 0.
  - Therefore ex_valid=0, id_ready=1, and every data output is 0.
- Slot state is one bit, EMPTY/FULL, held in slot_valid.
  - fire_in = id_valid & id_ready.
  - fire_out = ex_valid & ex_ready.
- Handshake:
  - id_ready = ~slot_valid | fire_out (combinational pass-through).
  - ex_valid = slot_valid & ~load_use.
- Next state, in priority order:
  - flush: slot_valid<=0, regardless of fire_in.
  - fire_in: capture all id_* fields; slot_valid<=1.
  - fire_out with no fire_in: slot_valid<=0.
  - Otherwise hold.
- Latency: an instruction accepted in cycle N is visible on the ex_* outputs in cycle N+1.
- Forwarding, per source s in {rs1, rs2}, using the registered index and data:
  - Hit on MEM when mem_fwd_en & mem_fwd_rd==s & s!=0.
  - Otherwise hit on WB when wb_fwd_en & wb_fwd_rd==s & s!=0.
  - Otherwise use the stored register data.
  - MEM has priority over WB. x0 is never forwarded.
- load_use is asserted when slot_valid & mem_fwd_is_load & a MEM hit exists on any source the instruction reads.
- Sticky refresh: while FULL and not firing out, on any WB hit the stored rs data is overwritten with wb_fwd_data. A forwarded value that retires during a stall is therefore never lost.
- Operand muxing:
  - alu_src1 = id_src1_pc ? pc : fwd_rs1.
  - alu_src2 = id_src2_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2, always.
- When slot_valid=0, the ex_* control flags are driven 0 (bubble), so a bubble never writes registers or memory.
- Reset asserted mid-operation drops the slot immediately, without waiting for the clock edge.

Decomposition:
- Shared header holds REG_WIDTH, ALU_OP_WIDTH, the ALU_* opcode encodings and REG_ADDR_WIDTH. No new typedefs are needed.
- One sub-module, fwd_mux: a combinational source resolver instantiated twice (rs1, rs2). Its outputs are the selected data, a mem_hit flag and a wb_hit flag.

Test Plan:
- Reset, then an ADD with rs1=x1=5, rs2=x2=7, ex_ready=1 -> next cycle ex_valid=1, alu_op=ADD, alu_src1=5, alu_src2=7. Back-to-back accepts run at 1/cycle.
- MEM forwarding x1=0x100, WB forwarding x1=0x200, both hitting rs1 -> alu_src1=0x100. Repeat with rs1=x0 and both buses targeting x0 -> alu_src1=0.
- Load in MEM with rd=x3 and the slot's rs2=x3 -> ex_valid=0 and id_ready=0. The next cycle the load moves to WB with data 0x55 -> ex_valid=1, alu_src2=0x55.
- ex_ready=0 for 3 cycles while WB writes rs1 (0xAA) in the first stall cycle only -> on release alu_src1=0xAA and the slot contents are otherwise unchanged.
- flush together with id_valid=1 on a full slot -> next cycle ex_valid=0 and id_ready=1. A store instruction issues no ex_mem_write.
- Assert rst_n=0 asynchronously while the slot is full and stalled -> ex_valid drops to 0 before the next clock edge.
